spike_aer_encoder: RTL and testbench

SPIKE_AER_ENCODER -- requirements
Module: spike_aer_encoder

---
 rtl/spike_aer_encoder.sv | 137 +++++++++++++
 tb/tb_spike_aer_encoder.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/spike_aer_encoder.sv
// rtl/spike_aer_encoder.sv - 8-neuron spike capture, round-robin arbiter and AER event FIFO
// Optional per-event timestamps are enabled by defining SPIKE_AER_TIMESTAMP_EN.
module spike_aer_encoder #(
  parameter int P_FIFO_DEPTH = 4,
  parameter int P_TS_W       = 8
) (
  input  logic              i_clk,
  input  logic              w_rst,
  input  logic [8:1]        i_spike,
  output logic [2:0]        o_aer_addr,
  output logic              o_aer_valid,
  input  logic              i_aer_ready,
  output logic [8:1]        o_pending,
  output logic              o_overflow,
  output logic [P_TS_W-1:0] o_ts
);

  localparam int AW = (P_FIFO_DEPTH > 2) ? $clog2(P_FIFO_DEPTH) : 1;
  localparam int CW = AW + 1;

  // Bit j of the internal vectors corresponds to neuron j+1.
  logic [7:0]    spike_w;
  logic [7:0]    pending_q, pending_d;
  logic [7:0]    grant_w;
  logic [7:0]    lost_w;
  // Arbiter pointer stored as (ptr - 1), so reset value 0 means ptr = 1.
  logic [2:0]    ptr_q;
  logic          overflow_q;
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q, count_d;
  logic [2:0]    addr_mem_q [P_FIFO_DEPTH];

  logic          grant_vld;
  logic [2:0]    grant_idx;
  logic [2:0]    scan_idx;
  logic          push_w, pop_w;

  assign spike_w = i_spike;

  // Round-robin search starting at ptr; grants only when the registered count leaves room.
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = 3'd0;
    scan_idx  = 3'd0;
    if (count_q < CW'(P_FIFO_DEPTH)) begin
      for (int i = 0; i < 8; i++) begin
        scan_idx = ptr_q + 3'(i);
        if (!grant_vld && pending_q[scan_idx]) begin
          grant_vld = 1'b1;
          grant_idx = scan_idx;
        end
      end
    end
  end

  assign grant_w   = grant_vld ? (8'(1) << grant_idx) : 8'd0;
  assign pending_d = (pending_q & ~grant_w) | spike_w;
  // A spike is lost only when it lands on an already-pending, ungranted neuron.
  assign lost_w    = spike_w & pending_q & ~grant_w;
  assign push_w    = grant_vld;
  assign pop_w     = (count_q != '0) && i_aer_ready;

  // Occupancy update; simultaneous push and pop cancel out.
  always_comb begin
    count_d = count_q;
    case ({push_w, pop_w})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Pending register, arbiter pointer and sticky overflow flag.
  always_ff @(posedge i_clk or negedge w_rst) begin
    if (!w_rst) begin
      pending_q  <= '0;
      ptr_q      <= 3'd0;
      overflow_q <= 1'b0;
    end else begin
      pending_q  <= pending_d;
      overflow_q <= overflow_q | (|lost_w);
      if (grant_vld) ptr_q <= grant_idx + 3'd1;
    end
  end

  // FIFO pointers and count; pointers wrap naturally at the power-of-2 depth.
  always_ff @(posedge i_clk or negedge w_rst) begin
    if (!w_rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_w) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop_w)  rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_d;
    end
  end

  // Event address storage; cleared on reset so the head address reads 0.
  always_ff @(posedge i_clk or negedge w_rst) begin
    if (!w_rst) begin
      for (int i = 0; i < P_FIFO_DEPTH; i++) addr_mem_q[i] <= 3'd0;
    end else if (push_w) begin
      addr_mem_q[wr_ptr_q] <= grant_idx;
    end
  end

  assign o_aer_addr  = addr_mem_q[rd_ptr_q];
  assign o_aer_valid = (count_q != '0);
  assign o_pending   = pending_q;
  assign o_overflow  = overflow_q;

`ifdef SPIKE_AER_TIMESTAMP_EN
  logic [P_TS_W-1:0] ts_cnt_q;
  logic [P_TS_W-1:0] ts_mem_q [P_FIFO_DEPTH];

  // Free-running timestamp counter, wraps to 0.
  always_ff @(posedge i_clk or negedge w_rst) begin
    if (!w_rst) ts_cnt_q <= '0;
    else        ts_cnt_q <= ts_cnt_q + P_TS_W'(1);
  end

  // Timestamp storage alongside each event; captures the counter value at the push edge.
  always_ff @(posedge i_clk or negedge w_rst) begin
    if (!w_rst) begin
      for (int i = 0; i < P_FIFO_DEPTH; i++) ts_mem_q[i] <= '0;
    end else if (push_w) begin
      ts_mem_q[wr_ptr_q] <= ts_cnt_q;
    end
  end

  assign o_ts = ts_mem_q[rd_ptr_q];
`else
  assign o_ts = '0;
`endif

endmodule

// File: tb/tb_spike_aer_encoder.sv
// tb/tb_spike_aer_encoder.sv - self-checking bench for spike_aer_encoder
module tb_spike_aer_encoder;

  localparam int DEPTH = 4;
  localparam int TSW   = 8;
`ifdef SPIKE_AER_TIMESTAMP_EN
  localparam bit TS_EN = 1'b1;
`else
  localparam bit TS_EN = 1'b0;
`endif

  logic           i_clk = 1'b0;
  logic           w_rst = 1'b0;
  logic [8:1]     i_spike = '0;
  logic [2:0]     o_aer_addr;
  logic           o_aer_valid;
  logic           i_aer_ready = 1'b0;
  logic [8:1]     o_pending;
  logic           o_overflow;
  logic [TSW-1:0] o_ts;

  int n_checks = 0;
  int n_errors = 0;

  spike_aer_encoder #(.P_FIFO_DEPTH(DEPTH), .P_TS_W(TSW)) dut (
    .i_clk(i_clk), .w_rst(w_rst), .i_spike(i_spike),
    .o_aer_addr(o_aer_addr), .o_aer_valid(o_aer_valid), .i_aer_ready(i_aer_ready),
    .o_pending(o_pending), .o_overflow(o_overflow), .o_ts(o_ts)
  );

  always #5 i_clk = ~i_clk;

  // Reference model: per-neuron pending flags, event queue, pointer as a neuron number 1..8.
  typedef struct { int addr; int ts; } ev_t;
  bit  m_pend [1:8];
  int  m_ptr;
  bit  m_ov;
  int  m_ts;
  ev_t m_q [$];

  task automatic chk(input string nm, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] m_pend_vec();
    logic [7:0] v;
    for (int n = 1; n <= 8; n++) v[n-1] = m_pend[n];
    return v;
  endfunction

  task automatic m_reset();
    for (int n = 1; n <= 8; n++) m_pend[n] = 1'b0;
    m_ptr = 1; m_ov = 1'b0; m_ts = 0;
    m_q.delete();
  endtask

  task automatic m_step(input logic [7:0] sp, input logic rdy);
    int  g;
    bit  found;
    ev_t e;
    g = 0; found = 1'b0;
    if (m_q.size() < DEPTH) begin
      for (int s = 0; s < 8; s++) begin
        int n;
        n = ((m_ptr - 1 + s) % 8) + 1;
        if (!found && m_pend[n]) begin found = 1'b1; g = n; end
      end
    end
    if (m_q.size() != 0 && rdy) void'(m_q.pop_front());
    for (int n = 1; n <= 8; n++) begin
      if (sp[n-1] && m_pend[n] && n != g) m_ov = 1'b1;
      if (n == g) m_pend[n] = sp[n-1];
      else        m_pend[n] = m_pend[n] | sp[n-1];
    end
    if (found) begin
      e.addr = g - 1;
      e.ts   = TS_EN ? m_ts : 0;
      m_q.push_back(e);
      m_ptr = (g % 8) + 1;
    end
    m_ts = (m_ts + 1) % (1 << TSW);
  endtask

  // Called just after a falling edge: check outputs against model, then advance one clock.
  task automatic step(input logic [7:0] sp, input logic rdy);
    i_spike = sp; i_aer_ready = rdy;
    #1;
    chk("model_valid", o_aer_valid, m_q.size() != 0);
    if (m_q.size() != 0) begin
      chk("model_addr", o_aer_addr, m_q[0].addr);
      chk("model_ts", o_ts, m_q[0].ts);
    end
    chk("model_pending", o_pending, m_pend_vec());
    chk("model_overflow", o_overflow, m_ov);
    m_step(sp, rdy);
    @(posedge i_clk);
    @(negedge i_clk);
  endtask

  task automatic do_reset();
    i_spike = '0; i_aer_ready = 1'b0;
    w_rst = 1'b0;
    #1;
    chk("rst_valid", o_aer_valid, 0);
    chk("rst_pending", o_pending, 0);
    chk("rst_overflow", o_overflow, 0);
    chk("rst_addr", o_aer_addr, 0);
    chk("rst_ts", o_ts, 0);
    m_reset();
    @(posedge i_clk);
    @(negedge i_clk);
    w_rst = 1'b1;
  endtask

  typedef struct {
    bit         do_rst;
    logic [7:0] sp;
    bit         rdy;
    bit         ev;
    logic [2:0] ea;
    logic [7:0] ep;
    bit         eo;
  } vec_t;

  vec_t tv [15];
  int   got [$];
  int   exp_q [$];

  task automatic collect(input int cycles, input logic rdy);
    got.delete();
    for (int c = 0; c < cycles; c++) begin
      if (o_aer_valid && rdy) got.push_back(int'(o_aer_addr));
      step(8'h00, rdy);
    end
  endtask

  task automatic cmp_seq(input string nm);
    chk({nm, "_len"}, got.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got.size(); i++) chk(nm, got[i], exp_q[i]);
  endtask

  initial begin
    m_reset();
    @(negedge i_clk);

    // Single spike latency, then full round-robin sweep from a fresh reset.
    tv[0]  = '{1, 8'h04, 1, 0, 0, 8'h00, 0};
    tv[1]  = '{0, 8'h00, 1, 0, 0, 8'h04, 0};
    tv[2]  = '{0, 8'h00, 1, 1, 2, 8'h00, 0};
    tv[3]  = '{0, 8'h00, 1, 0, 0, 8'h00, 0};
    tv[4]  = '{1, 8'hFF, 1, 0, 0, 8'h00, 0};
    tv[5]  = '{0, 8'h00, 1, 0, 0, 8'hFF, 0};
    tv[6]  = '{0, 8'h00, 1, 1, 0, 8'hFE, 0};
    tv[7]  = '{0, 8'h00, 1, 1, 1, 8'hFC, 0};
    tv[8]  = '{0, 8'h00, 1, 1, 2, 8'hF8, 0};
    tv[9]  = '{0, 8'h00, 1, 1, 3, 8'hF0, 0};
    tv[10] = '{0, 8'h00, 1, 1, 4, 8'hE0, 0};
    tv[11] = '{0, 8'h00, 1, 1, 5, 8'hC0, 0};
    tv[12] = '{0, 8'h00, 1, 1, 6, 8'h80, 0};
    tv[13] = '{0, 8'h00, 1, 1, 7, 8'h00, 0};
    tv[14] = '{0, 8'h00, 1, 0, 0, 8'h00, 0};
    for (int i = 0; i < 15; i++) begin
      if (tv[i].do_rst) do_reset();
      #1;
      chk("tbl_valid", o_aer_valid, tv[i].ev);
      if (tv[i].ev) chk("tbl_addr", o_aer_addr, tv[i].ea);
      chk("tbl_pending", o_pending, tv[i].ep);
      chk("tbl_overflow", o_overflow, tv[i].eo);
      step(tv[i].sp, tv[i].rdy);
    end

    // Backpressure: four events queue, rest stay pending, head held stable.
    do_reset();
    step(8'hFF, 1'b0);
    for (int c = 0; c < 5; c++) step(8'h00, 1'b0);
    for (int c = 0; c < 3; c++) begin
      chk("bp_valid", o_aer_valid, 1);
      chk("bp_addr", o_aer_addr, 0);
      chk("bp_pending", o_pending, 8'hF0);
      if (!TS_EN) chk("bp_ts_zero", o_ts, 0);
      step(8'h00, 1'b0);
    end
    collect(20, 1'b1);
    exp_q = '{0, 1, 2, 3, 4, 5, 6, 7};
    cmp_seq("bp_order");
    chk("bp_overflow", o_overflow, 0);

    // Overflow: FIFO full, neuron 1 spikes twice while already pending.
    do_reset();
    step(8'h0F, 1'b0);
    for (int c = 0; c < 5; c++) step(8'h00, 1'b0);
    step(8'h01, 1'b0);
    chk("ov_not_yet", o_overflow, 0);
    step(8'h00, 1'b0);
    step(8'h01, 1'b0);
    for (int c = 0; c < 3; c++) begin
      chk("ov_sticky", o_overflow, 1);
      step(8'h00, 1'b0);
    end
    collect(20, 1'b1);
    exp_q = '{0, 1, 2, 3, 0};
    cmp_seq("ov_order");
    chk("ov_after", o_overflow, 1);

    // Reset mid-operation with three queued events and 8'h30 pending.
    do_reset();
    step(8'h37, 1'b0);
    for (int c = 0; c < 3; c++) step(8'h00, 1'b0);
    #1;
    chk("mid_valid_pre", o_aer_valid, 1);
    chk("mid_pending_pre", o_pending, 8'h30);
    do_reset();
    #1;
    chk("mid_first_cycle", o_aer_valid, 0);
    step(8'h80, 1'b1);
    chk("mid_n1", o_aer_valid, 0);
    step(8'h00, 1'b1);
    chk("mid_n2_valid", o_aer_valid, 1);
    chk("mid_n2_addr", o_aer_addr, 7);
    step(8'h00, 1'b1);
    chk("mid_n3_valid", o_aer_valid, 0);

`ifdef SPIKE_AER_TIMESTAMP_EN
    // Timestamp capture around the counter wrap.
    do_reset();
    got.delete();
    for (int c = 0; c < 266; c++) begin
      if (o_aer_valid) got.push_back(int'(o_ts));
      step((c == 254 || c == 257) ? 8'h01 : 8'h00, 1'b1);
    end
    exp_q = '{8'hFF, 8'h02};
    cmp_seq("ts_wrap");
`endif

    // Randomized traffic against the model.
    do_reset();
    for (int c = 0; c < 600; c++) begin
      logic [7:0] sp;
      for (int b = 0; b < 8; b++) sp[b] = ($urandom_range(0, 5) == 0);
      step(sp, ($urandom_range(0, 9) < 7));
    end
    for (int c = 0; c < 30; c++) step(8'h00, 1'b1);
    chk("rand_drained", o_aer_valid, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
